// File: rtl/multi_channel_fault_monitor_if.sv
// Handshake bundle for the multi-channel supply fault monitor.
// master drives samples/controls, slave (the monitor) returns fault status.
interface multi_channel_fault_monitor_if #(
    parameter int NUM_CH = 4,
    parameter int DATA_W = 12
);
    localparam int FF_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic                     sample_valid;
    logic [NUM_CH*DATA_W-1:0] voltage_in;
    logic [NUM_CH-1:0]        ch_enable;
    logic                     fault_clear;
    logic                     fault_detected;
    logic [NUM_CH-1:0]        fault_ch;
    logic [NUM_CH-1:0]        fault_high;
    logic [FF_W-1:0]          first_fault;
    logic [NUM_CH*8-1:0]      fault_count;

    modport master (
        output sample_valid, voltage_in, ch_enable, fault_clear,
        input  fault_detected, fault_ch, fault_high,
        input  first_fault, fault_count
    );

    modport slave (
        input  sample_valid, voltage_in, ch_enable, fault_clear,
        output fault_detected, fault_ch, fault_high,
        output first_fault, fault_count
    );
endinterface

// File: rtl/multi_channel_fault_monitor.sv
// Per-channel debounced under/over-voltage fault latch with hysteresis clear.
// Optional FAULT_COUNT_EN adds saturating 8-bit per-channel fault event counters.
module multi_channel_fault_monitor #(
    parameter int NUM_CH   = 4,
    parameter int DATA_W   = 12,
    parameter int V_MIN    = 1000,
    parameter int V_MAX    = 3000,
    parameter int DEBOUNCE = 4,
    parameter int HYST     = 50
) (
    input logic clk,
    input logic reset,
    multi_channel_fault_monitor_if.slave mon
);
    localparam int FF_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int CLR_LO  = V_MIN + HYST;
    localparam int CLR_HI  = V_MAX - HYST;
    localparam bit BAND_OK = (CLR_HI >= CLR_LO) && (CLR_HI >= 0);
    localparam logic [7:0] DEB = 8'(DEBOUNCE);

    typedef enum logic [1:0] {
        ST_OK,
        ST_PEND,
        ST_FAULT
    } state_t;

    state_t            st_q   [NUM_CH];
    state_t            st_d   [NUM_CH];
    logic [7:0]        cnt_q  [NUM_CH];
    logic [7:0]        cnt_d  [NUM_CH];
    logic [NUM_CH-1:0] high_q;
    logic [NUM_CH-1:0] high_d;
    logic [NUM_CH-1:0] flt_q;
    logic [NUM_CH-1:0] flt_d;
    logic [NUM_CH-1:0] lo_s;
    logic [NUM_CH-1:0] hi_s;
    logic [NUM_CH-1:0] band_s;
    logic [FF_W-1:0]   ff_q;
    logic [FF_W-1:0]   ff_d;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_dec
        logic [DATA_W-1:0] samp;
        logic [31:0]       s32;
        assign samp      = mon.voltage_in[g*DATA_W +: DATA_W];
        assign s32       = 32'(samp);
        assign lo_s[g]   = samp < DATA_W'(V_MIN);
        assign hi_s[g]   = samp > DATA_W'(V_MAX);
        // Band limits are evaluated wider than DATA_W so they never wrap.
        assign band_s[g] = BAND_OK && (s32 >= 32'(CLR_LO))
                           && (s32 <= 32'(CLR_HI));
        assign flt_q[g]  = (st_q[g] == ST_FAULT);
    end

    always_comb begin
        ff_d = ff_q;
        for (int i = 0; i < NUM_CH; i++) begin
            st_d[i]   = st_q[i];
            cnt_d[i]  = cnt_q[i];
            high_d[i] = high_q[i];
            unique case (st_q[i])
                ST_OK, ST_PEND: begin
                    if (!mon.ch_enable[i]) begin
                        st_d[i]  = ST_OK;
                        cnt_d[i] = 8'd0;
                    end else if (mon.sample_valid) begin
                        if (lo_s[i] || hi_s[i]) begin
                            if (cnt_q[i] + 8'd1 >= DEB) begin
                                st_d[i]   = ST_FAULT;
                                cnt_d[i]  = 8'd0;
                                high_d[i] = hi_s[i];
                            end else begin
                                st_d[i]  = ST_PEND;
                                cnt_d[i] = cnt_q[i] + 8'd1;
                            end
                        end else begin
                            st_d[i]  = ST_OK;
                            cnt_d[i] = 8'd0;
                        end
                    end
                end
                ST_FAULT: begin
                    if (mon.fault_clear && band_s[i]) begin
                        st_d[i]   = ST_OK;
                        cnt_d[i]  = 8'd0;
                        high_d[i] = 1'b0;
                    end
                end
                default: begin
                    st_d[i]   = ST_OK;
                    cnt_d[i]  = 8'd0;
                    high_d[i] = 1'b0;
                end
            endcase
            flt_d[i] = (st_d[i] == ST_FAULT);
        end
        // Lowest index wins when several channels trip on the rising edge.
        if (!(|flt_q) && (|flt_d)) begin
            for (int i = NUM_CH - 1; i >= 0; i--) begin
                if (flt_d[i]) ff_d = FF_W'(i);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_CH; i++) begin
                st_q[i]  <= ST_OK;
                cnt_q[i] <= 8'd0;
            end
            high_q <= '0;
            ff_q   <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                st_q[i]  <= st_d[i];
                cnt_q[i] <= cnt_d[i];
            end
            high_q <= high_d;
            ff_q   <= ff_d;
        end
    end

    assign mon.fault_ch       = flt_q;
    assign mon.fault_high     = high_q;
    assign mon.fault_detected = |flt_q;
    assign mon.first_fault    = ff_q;

`ifdef FAULT_COUNT_EN
    logic [7:0] fc_q [NUM_CH];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_CH; i++) fc_q[i] <= 8'd0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (!flt_q[i] && flt_d[i] && fc_q[i] != 8'hFF)
                    fc_q[i] <= fc_q[i] + 8'd1;
            end
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_cnt
        assign mon.fault_count[g*8 +: 8] = fc_q[g];
    end
`else
    assign mon.fault_count = '0;
`endif

endmodule

// File: tb/tb_multi_channel_fault_monitor.sv
// Directed bench for multi_channel_fault_monitor with a rule-level model.
// Model and literal checks both feed the same pass/fail counters.
module tb_multi_channel_fault_monitor;
    localparam int NC  = 4;
    localparam int DW  = 12;
    localparam int DEB = 4;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int total = 0;
    int bad = 0;

    multi_channel_fault_monitor_if #(.NUM_CH(NC), .DATA_W(DW)) mon();

    multi_channel_fault_monitor #(
        .NUM_CH(NC), .DATA_W(DW), .V_MIN(1000), .V_MAX(3000),
        .DEBOUNCE(DEB), .HYST(50)
    ) dut (
        .clk(clk),
        .reset(reset),
        .mon(mon.slave)
    );

    always #5 clk = ~clk;

    // Rule-level model state: run length of out-of-range samples,
    // latched flag/cause, first-fault index, event counts.
    int  run  [NC];
    bit  mf   [NC];
    bit  mh   [NC];
    int  mcnt [NC];
    int  mff;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%0h exp=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic int samp(input int c);
        logic [NC*DW-1:0] v;
        v = mon.voltage_in;
        return int'(v[c*DW +: DW]);
    endfunction

    task automatic model_step();
        bit any_old, any_new;
        any_old = 0;
        any_new = 0;
        for (int c = 0; c < NC; c++) any_old |= mf[c];
        if (reset) begin
            for (int c = 0; c < NC; c++) begin
                run[c] = 0; mf[c] = 0; mh[c] = 0; mcnt[c] = 0;
            end
            mff = 0;
            return;
        end
        for (int c = 0; c < NC; c++) begin
            int s;
            bit out;
            s = samp(c);
            out = (s < 1000) || (s > 3000);
            if (!mf[c]) begin
                if (!mon.ch_enable[c]) run[c] = 0;
                else if (mon.sample_valid) begin
                    if (out) begin
                        run[c]++;
                        if (run[c] >= DEB) begin
                            mf[c] = 1;
                            mh[c] = (s > 3000);
                            run[c] = 0;
                            if (mcnt[c] < 255) mcnt[c]++;
                        end
                    end else run[c] = 0;
                end
            end else if (mon.fault_clear && s >= 1050 && s <= 2950) begin
                mf[c] = 0;
                mh[c] = 0;
                run[c] = 0;
            end
        end
        for (int c = 0; c < NC; c++) any_new |= mf[c];
        if (!any_old && any_new) begin
            for (int c = NC - 1; c >= 0; c--) if (mf[c]) mff = c;
        end
    endtask

    always @(posedge clk) begin
        logic [NC-1:0] ef, eh;
        logic [NC*8-1:0] ec;
        model_step();
        #1;
        ef = '0;
        eh = '0;
        ec = '0;
        for (int c = 0; c < NC; c++) begin
            ef[c] = mf[c];
            eh[c] = mh[c];
`ifdef FAULT_COUNT_EN
            ec[c*8 +: 8] = 8'(mcnt[c]);
`endif
        end
        chk("m_fault_ch", 64'(mon.fault_ch), 64'(ef));
        chk("m_fault_high", 64'(mon.fault_high), 64'(eh));
        chk("m_detected", 64'(mon.fault_detected), 64'(|ef));
        chk("m_first", 64'(mon.first_fault), 64'(mff));
        chk("m_count", 64'(mon.fault_count), 64'(ec));
    end

    task automatic cyc(input bit v, input int a, input int b, input int c,
                       input int d, input logic [3:0] en = 4'hF,
                       input bit clr = 0, input bit rst = 0);
        @(negedge clk);
        mon.sample_valid = v;
        mon.voltage_in = {DW'(d), DW'(c), DW'(b), DW'(a)};
        mon.ch_enable = en;
        mon.fault_clear = clr;
        reset = rst;
        @(posedge clk);
        #2;
    endtask

    task automatic ok_cycle(input bit clr = 0);
        cyc(1, 2000, 2000, 2000, 2000, 4'hF, clr);
    endtask

    initial begin
        mon.sample_valid = 0;
        mon.voltage_in = {4{DW'(2000)}};
        mon.ch_enable = 4'hF;
        mon.fault_clear = 0;
        cyc(0, 2000, 2000, 2000, 2000, 4'hF, 0, 1);
        cyc(0, 2000, 2000, 2000, 2000, 4'hF, 0, 1);
        chk("rst_fault_ch", 64'(mon.fault_ch), 64'h0);
        chk("rst_detected", 64'(mon.fault_detected), 64'h0);
        chk("rst_count", 64'(mon.fault_count), 64'h0);

        repeat (20) ok_cycle();
        chk("quiet_detected", 64'(mon.fault_detected), 64'h0);
        chk("quiet_first", 64'(mon.first_fault), 64'h0);

        repeat (3) cyc(1, 2000, 2000, 500, 2000);
        ok_cycle();
        chk("short_glitch", 64'(mon.fault_ch), 64'h0);

        repeat (3) cyc(1, 2000, 2000, 500, 2000);
        chk("ch2_pre", 64'(mon.fault_ch), 64'h0);
        cyc(1, 2000, 2000, 500, 2000);
        chk("ch2_fault", 64'(mon.fault_ch), 64'h4);
        chk("ch2_low", 64'(mon.fault_high), 64'h0);
        chk("ch2_det", 64'(mon.fault_detected), 64'h1);
        chk("ch2_first", 64'(mon.first_fault), 64'h2);
        ok_cycle(1);
        chk("ch2_clr", 64'(mon.fault_ch), 64'h0);
        chk("first_hold", 64'(mon.first_fault), 64'h2);

        repeat (4) cyc(1, 2000, 3500, 2000, 3500);
        chk("ch13_fault", 64'(mon.fault_ch), 64'hA);
        chk("ch13_high", 64'(mon.fault_high), 64'hA);
        chk("ch13_first", 64'(mon.first_fault), 64'h1);
        ok_cycle(1);
        chk("ch13_clr", 64'(mon.fault_ch), 64'h0);

        repeat (4) cyc(1, 3500, 2000, 2000, 2000);
        chk("ch0_high", 64'(mon.fault_high), 64'h1);
        cyc(0, 2980, 2000, 2000, 2000, 4'hF, 1);
        chk("ch0_noband", 64'(mon.fault_ch), 64'h1);
        cyc(0, 2500, 2000, 2000, 2000, 4'hF, 1);
        chk("ch0_clr", 64'(mon.fault_ch), 64'h0);
        chk("ch0_clr_det", 64'(mon.fault_detected), 64'h0);

        cyc(1, 500, 2000, 2000, 2000);
        cyc(1, 3500, 2000, 2000, 2000);
        cyc(1, 500, 2000, 2000, 2000);
        cyc(1, 3500, 2000, 2000, 2000);
        chk("mixed_fault", 64'(mon.fault_ch), 64'h1);
        chk("mixed_high", 64'(mon.fault_high), 64'h1);
        ok_cycle(1);

        repeat (3) cyc(1, 500, 2000, 2000, 2000);
        cyc(1, 500, 2000, 2000, 2000, 4'hF, 1);
        chk("clr_vs_new", 64'(mon.fault_ch), 64'h1);
        ok_cycle(1);

        repeat (10) cyc(1, 2000, 2000, 2000, 0, 4'h7);
        chk("dis_nofault", 64'(mon.fault_ch), 64'h0);
        repeat (3) cyc(1, 2000, 2000, 2000, 0);
        chk("reen_pre", 64'(mon.fault_ch), 64'h0);
        cyc(1, 2000, 2000, 2000, 0);
        chk("reen_fault", 64'(mon.fault_ch), 64'h8);
        cyc(1, 2000, 2000, 2000, 0, 4'h7);
        chk("dis_latched", 64'(mon.fault_ch), 64'h8);
        cyc(0, 2000, 2000, 2000, 2000, 4'h7, 1);
        chk("dis_clr", 64'(mon.fault_ch), 64'h0);

        repeat (2) cyc(1, 2000, 2000, 500, 2000);
        cyc(1, 2000, 2000, 500, 2000, 4'hF, 0, 1);
        chk("midrst_ch", 64'(mon.fault_ch), 64'h0);
        chk("midrst_first", 64'(mon.first_fault), 64'h0);
        repeat (3) cyc(1, 2000, 2000, 500, 2000);
        chk("postrst_pre", 64'(mon.fault_ch), 64'h0);
        cyc(1, 2000, 2000, 500, 2000);
        chk("postrst_fault", 64'(mon.fault_ch), 64'h4);
        ok_cycle(1);

        repeat (3) begin
            repeat (4) cyc(1, 500, 2000, 2000, 2000);
            ok_cycle(1);
        end
        ok_cycle(1);
`ifdef FAULT_COUNT_EN
        chk("cnt_ch0", 64'(mon.fault_count[7:0]), 64'd3);
        chk("cnt_ch2", 64'(mon.fault_count[23:16]), 64'd1);
`else
        chk("cnt_off", 64'(mon.fault_count), 64'h0);
`endif
        cyc(0, 2000, 2000, 2000, 2000, 4'hF, 0, 1);
        chk("cnt_rst", 64'(mon.fault_count), 64'h0);
        ok_cycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
